npc_predict_unit: RTL and testbench
===================================

Name: npc_predict_unit

Overview:
- Parametrised next-PC generator for the pipelined core. Owns the fetch PC register and predicts the next fetch address with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters.
- Resolves the actual next PC from execute-stage control and raises a flush on misprediction.
- Sits between IF (drives instruction address) and EX (receives resolution).
- Replaces the purely combinational next-PC selector.

Parameters:
- XLEN, 32, datapath/PC width in bits.
- BTB_ENTRIES, 16, number of BTB entries; power of two, ≥2. IDXW = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset (XLEN bits).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold fetch PC (IF/ID stalled).
- fetch_pc  out  XLEN  current fetch address (registered).
- pred_taken  out  1  BTB predicts taken for fetch_pc.
- pred_npc  out  XLEN  predicted next fetch address, to be piped to EX with the instruction.
- ex_valid  in  1  EX holds a valid instruction this cycle.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_op  in  3  next-PC select: 0 PC+4, 1 conditional branch, 2 PC+offset (jal), 3 register target (jalr); 4–7 treated as 0.
- ex_offset  in  XLEN  sign-extended immediate.
- ex_br  in  1  branch condition from ALU (used only when ex_op=1).
- ex_regpc  in  XLEN  jalr target, already LSB-cleared upstream.
- ex_pred_npc  in  XLEN  pred_npc carried with the EX instruction.
- ex_pc4  out  XLEN  ex_pc+4, for rd writeback of jal/jalr.
- flush  out  1  misprediction; kill IF/ID contents.
- mispredict_cnt  out  32  saturating count of mispredictions.

Behaviour:
- Arithmetic: all additions modulo 2^XLEN; wrap-around is not detected.
- BTB entry fields: valid, tag = pc[XLEN-1:IDXW+2], target (XLEN), ctr (2 bits). Index = pc[IDXW+1:2].
- Lookup (combinational on fetch_pc):
  - hit = valid && tag match.
  - pred_taken = hit && ctr≥2.
  - pred_npc = target if pred_taken, else fetch_pc+4.
- Resolution (combinational):
  - actual_npc = ex_pc+ex_offset for op 2, or op 1 with ex_br=1; ex_regpc for op 3; ex_pc+4 otherwise.
  - actual_taken = (op 2|3) || (op 1 && ex_br).
  - flush = ex_valid && (actual_npc != ex_pred_npc). Asserted in the same cycle as resolution.
- fetch_pc next-state priority:
  1. rst → RESET_PC.
  2. flush → actual_npc (overrides stall).
  3. stall → hold.
  4. else → pred_npc.
- BTB update, at the edge, when ex_valid && op∈{1,2,3} && !rst:
  - Hit at ex_pc: ctr saturating ±1 (inc if actual_taken, else dec; 3 stays 3, 0 stays 0). target ← actual_npc when actual_taken.
  - Miss && actual_taken: allocate/overwrite entry with valid=1, tag, target=actual_npc, ctr=2.
  - Miss && not taken: no change.
  - op 0/4–7: no BTB change.
- Same-cycle update and lookup of the same index: lookup returns the pre-update contents; the write takes effect next cycle.
- mispredict_cnt increments once per cycle with flush=1; saturates at 32'hFFFF_FFFF.
- Reset (synchronous, any time including mid-flush or stall):
  - fetch_pc=RESET_PC; all valid=0; all ctr=1; mispredict_cnt=0.
  - Post-reset outputs: pred_taken=0, pred_npc=RESET_PC+4, flush follows the inputs combinationally (downstream ignores it during rst).
  - ex_pc4 is purely combinational; no reset value.
- ex_valid=0: flush=0; no BTB or counter change.
- Latency: prediction 0 cycles (combinational from fetch_pc). Redirect takes effect on fetch_pc 1 cycle after flush.

Test Plan:
- Reset: hold rst 2 cycles with RESET_PC=0x100 → fetch_pc=0x100, pred_npc=0x104, mispredict_cnt=0. Release with stall=0 → fetch_pc steps 0x104, 0x108.
- Cold taken branch:
  - ex_valid=1, ex_pc=0x108, op=1, br=1, offset=0x20, ex_pred_npc=0x10C → flush=1, next fetch_pc=0x128, mispredict_cnt=1.
  - BTB[2] = {valid, target 0x128, ctr=2}.
  - Later fetch_pc=0x108 → pred_taken=1, pred_npc=0x128.
- Counter saturation/decay:
  - Resolve 0x108 taken twice more → ctr=3 (stays 3 on a further taken).
  - Then not-taken with ex_pred_npc=0x128 → flush=1, actual 0x10C, ctr=2; pred_taken remains 1.
  - A second not-taken → ctr=1, pred_taken=0.
- jalr: op=3, ex_regpc=0x400, ex_pc=0x200, ex_pred_npc=0x204 → flush=1, ex_pc4=0x204, fetch_pc=0x400 next cycle.
- Redirect vs stall: stall=1 with a mispredicting EX → fetch_pc loads actual_npc. stall=1 with no flush → fetch_pc holds for 3 cycles.
- Aliasing/overwrite: BTB_ENTRIES=16, taken branch at 0x108, then taken branch at 0x148 (same index, different tag) → entry re-tagged, target replaced, ctr=2. Fetch at 0x108 → pred_taken=0.

Source files
------------

// File: rtl/npc_predict_unit.sv
// Next-PC generator: owns the fetch PC, predicts the next fetch address from a
// direct-mapped BTB of 2-bit saturating counters, resolves the real next PC from
// execute-stage control and raises a flush when the prediction was wrong.
module npc_predict_unit #(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_npc,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [2:0]      ex_op,
    input  logic [XLEN-1:0] ex_offset,
    input  logic            ex_br,
    input  logic [XLEN-1:0] ex_regpc,
    input  logic [XLEN-1:0] ex_pred_npc,
    output logic [XLEN-1:0] ex_pc4,
    output logic            flush,
    output logic [31:0]     mispredict_cnt
);

    localparam int IDXW = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JAL    = 3'd2;
    localparam logic [2:0] OP_JALR   = 3'd3;

    // BTB storage; only valid and ctr need a reset value
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAGW-1:0]        btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    logic [IDXW-1:0] fetch_idx;
    logic [TAGW-1:0] fetch_tag;
    logic            fetch_hit;
    logic [IDXW-1:0] ex_idx;
    logic [TAGW-1:0] ex_tag;
    logic            ex_hit;
    logic            ex_ctrl;
    logic            actual_taken;
    logic [XLEN-1:0] actual_npc;

    assign fetch_idx = fetch_pc[IDXW+1:2];
    assign fetch_tag = fetch_pc[XLEN-1:IDXW+2];
    assign ex_idx    = ex_pc[IDXW+1:2];
    assign ex_tag    = ex_pc[XLEN-1:IDXW+2];
    assign ex_pc4    = ex_pc + XLEN'(4);

    // Lookup sees the pre-update BTB contents, so a same-cycle write lands next cycle
    always_comb begin
        fetch_hit  = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
        pred_taken = fetch_hit && btb_ctr[fetch_idx][1];
        pred_npc   = pred_taken ? btb_target[fetch_idx] : fetch_pc + XLEN'(4);
        ex_hit     = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
    end

    // Resolve the true next PC of the EX instruction; ops 4-7 fall through as sequential
    always_comb begin
        actual_npc   = ex_pc4;
        actual_taken = 1'b0;
        ex_ctrl      = 1'b0;
        case (ex_op)
            OP_BRANCH: begin
                ex_ctrl = 1'b1;
                if (ex_br) begin
                    actual_taken = 1'b1;
                    actual_npc   = ex_pc + ex_offset;
                end
            end
            OP_JAL: begin
                ex_ctrl      = 1'b1;
                actual_taken = 1'b1;
                actual_npc   = ex_pc + ex_offset;
            end
            OP_JALR: begin
                ex_ctrl      = 1'b1;
                actual_taken = 1'b1;
                actual_npc   = ex_regpc;
            end
            default: begin
                ex_ctrl = 1'b0;
            end
        endcase
        flush = ex_valid && (actual_npc != ex_pred_npc);
    end

    // Fetch PC: reset, then redirect (beats stall), then hold on stall, else follow prediction
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (flush) begin
            fetch_pc <= actual_npc;
        end else if (!stall) begin
            fetch_pc <= pred_npc;
        end
    end

    // Count flush cycles, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_cnt <= '0;
        end else if (flush && (mispredict_cnt != 32'hFFFF_FFFF)) begin
            mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

    // Valid bits and counters: train on a hit, allocate weakly-taken on a taken miss
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_ctr[i] <= 2'b01;
            end
        end else if (ex_valid && ex_ctrl) begin
            if (ex_hit) begin
                if (actual_taken && (btb_ctr[ex_idx] != 2'b11)) begin
                    btb_ctr[ex_idx] <= btb_ctr[ex_idx] + 2'b01;
                end else if (!actual_taken && (btb_ctr[ex_idx] != 2'b00)) begin
                    btb_ctr[ex_idx] <= btb_ctr[ex_idx] - 2'b01;
                end
            end else if (actual_taken) begin
                btb_valid[ex_idx] <= 1'b1;
                btb_ctr[ex_idx]   <= 2'b10;
            end
        end
    end

    // Tags and targets carry no reset; they only matter once the valid bit is set
    always_ff @(posedge clk) begin
        if (!rst && ex_valid && ex_ctrl && actual_taken) begin
            btb_target[ex_idx] <= actual_npc;
            if (!ex_hit) begin
                btb_tag[ex_idx] <= ex_tag;
            end
        end
    end

endmodule

// File: tb/tb_npc_predict_unit.sv
// Scoreboard bench for npc_predict_unit: a stimulus process pushes expected
// outputs from an abstract BTB model, a monitor process pops and compares them.
module tb_npc_predict_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [2:0]  ex_op;
    logic [31:0] ex_offset;
    logic        ex_br;
    logic [31:0] ex_regpc;
    logic [31:0] ex_pred_npc;
    logic [31:0] ex_pc4;
    logic        flush;
    logic [31:0] mispredict_cnt;

    npc_predict_unit #(
        .XLEN(32),
        .BTB_ENTRIES(16),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .fetch_pc(fetch_pc),
        .pred_taken(pred_taken),
        .pred_npc(pred_npc),
        .ex_valid(ex_valid),
        .ex_pc(ex_pc),
        .ex_op(ex_op),
        .ex_offset(ex_offset),
        .ex_br(ex_br),
        .ex_regpc(ex_regpc),
        .ex_pred_npc(ex_pred_npc),
        .ex_pc4(ex_pc4),
        .flush(flush),
        .mispredict_cnt(mispredict_cnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] fetch_pc;
        logic        pred_taken;
        logic [31:0] pred_npc;
        logic        flush;
        logic [31:0] ex_pc4;
        logic [31:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   numChecks = 0;
    int   numFails  = 0;

    // Abstract model: per-index table, counters as plain integers 0..3
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_fetch;
    logic [31:0] m_cnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int modelIdx(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic bit modelHit(input logic [31:0] pc);
        int idx = modelIdx(pc);
        return m_valid[idx] && (m_tag[idx] == (pc >> 6));
    endfunction

    function automatic bit modelTakenAt(input logic [31:0] pc);
        return modelHit(pc) && (m_ctr[modelIdx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] modelPredict(input logic [31:0] pc);
        if (modelTakenAt(pc)) return m_tgt[modelIdx(pc)];
        return pc + 32'd4;
    endfunction

    function automatic int effOp(input logic [2:0] op);
        return (op > 3'd3) ? 0 : int'(op);
    endfunction

    function automatic bit modelTaken(input logic [2:0] op, input logic br);
        int o = effOp(op);
        return (o == 2) || (o == 3) || (o == 1 && br);
    endfunction

    function automatic logic [31:0] modelActual(input logic [2:0] op, input logic [31:0] pc,
                                                input logic [31:0] off, input logic br,
                                                input logic [31:0] regpc);
        int o = effOp(op);
        if (o == 3) return regpc;
        if (o == 2 || (o == 1 && br)) return pc + off;
        return pc + 32'd4;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_fetch = RPC;
        m_cnt   = 32'd0;
    endtask

    // Drive one cycle, push its expected outputs, advance the model across the edge
    task automatic applyStimulus(input logic r, input logic s, input logic v,
                                 input logic [31:0] pc, input logic [2:0] op,
                                 input logic [31:0] off, input logic br,
                                 input logic [31:0] regpc, input logic [31:0] pnpc);
        exp_t        e;
        logic [31:0] act;
        logic [31:0] nxt;
        bit          tk;
        int          idx;
        rst = r; stall = s; ex_valid = v; ex_pc = pc; ex_op = op;
        ex_offset = off; ex_br = br; ex_regpc = regpc; ex_pred_npc = pnpc;
        act          = modelActual(op, pc, off, br, regpc);
        tk           = modelTaken(op, br);
        e.fetch_pc   = m_fetch;
        e.pred_taken = modelTakenAt(m_fetch);
        e.pred_npc   = modelPredict(m_fetch);
        e.flush      = v && (act != pnpc);
        e.ex_pc4     = pc + 32'd4;
        e.cnt        = m_cnt;
        sbq.push_back(e);
        if (r) begin
            modelReset();
        end else begin
            nxt = e.flush ? act : (s ? m_fetch : e.pred_npc);
            if (e.flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (v && effOp(op) >= 1) begin
                idx = modelIdx(pc);
                if (modelHit(pc)) begin
                    m_ctr[idx] = tk ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                                    : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
                    if (tk) m_tgt[idx] = act;
                end else if (tk) begin
                    m_valid[idx] = 1'b1;
                    m_tag[idx]   = pc >> 6;
                    m_tgt[idx]   = act;
                    m_ctr[idx]   = 2;
                end
            end
            m_fetch = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic s);
        applyStimulus(1'b0, s, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic jumpTo(input logic [31:0] target);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0E0, 3'd2, target - 32'h0E0, 1'b0, 32'h0, 32'h0E4);
    endtask

    // Monitor: every cycle with a pending expectation, compare all outputs at the falling edge
    exp_t mon;
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon = sbq.pop_front();
            checkOutput("fetch_pc",       fetch_pc,       mon.fetch_pc);
            checkOutput("pred_taken",     32'(pred_taken), 32'(mon.pred_taken));
            checkOutput("pred_npc",       pred_npc,       mon.pred_npc);
            checkOutput("flush",          32'(flush),      32'(mon.flush));
            checkOutput("ex_pc4",         ex_pc4,         mon.ex_pc4);
            checkOutput("mispredict_cnt", mispredict_cnt, mon.cnt);
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, then randomized traffic
    initial begin
        logic [31:0] pc;
        logic [31:0] off;
        logic [31:0] rpc;
        logic [31:0] pn;
        logic [2:0]  op;
        logic        br;
        rst = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_op = '0;
        ex_offset = '0; ex_br = 1'b0; ex_regpc = '0; ex_pred_npc = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        modelReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        checkOutput("reset_fetch_pc", fetch_pc, 32'h100);
        checkOutput("reset_pred_npc", pred_npc, 32'h104);
        checkOutput("reset_pred_taken", 32'(pred_taken), 32'h0);
        checkOutput("reset_cnt", mispredict_cnt, 32'h0);

        idle(1'b0);
        checkOutput("step_0x104", fetch_pc, 32'h104);
        idle(1'b0);
        checkOutput("step_0x108", fetch_pc, 32'h108);

        // cold taken branch
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h108, 3'd1, 32'h20, 1'b1, 32'h0, 32'h10C);
        checkOutput("cold_redirect", fetch_pc, 32'h128);
        checkOutput("cold_cnt", mispredict_cnt, 32'h1);
        jumpTo(32'h108);
        checkOutput("btb_hit_taken", 32'(pred_taken), 32'h1);
        checkOutput("btb_hit_target", pred_npc, 32'h128);

        // saturate, then decay while stalled
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 32'h108, 3'd1, 32'h20, 1'b1, 32'h0, 32'h128);
        checkOutput("stall_hold_sat", fetch_pc, 32'h108);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h108, 3'd1, 32'h20, 1'b0, 32'h0, 32'h128);
        checkOutput("flush_beats_stall", fetch_pc, 32'h10C);
        checkOutput("cnt_after_nt", mispredict_cnt, 32'h3);
        jumpTo(32'h108);
        checkOutput("ctr2_still_taken", 32'(pred_taken), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h108, 3'd1, 32'h20, 1'b0, 32'h0, 32'h128);
        jumpTo(32'h108);
        checkOutput("ctr1_not_taken", 32'(pred_taken), 32'h0);
        checkOutput("ctr1_pred_npc", pred_npc, 32'h10C);

        // jalr
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h200, 3'd3, 32'h0, 1'b0, 32'h400, 32'h204);
        checkOutput("jalr_pc4", ex_pc4, 32'h204);
        checkOutput("jalr_redirect", fetch_pc, 32'h400);
        repeat (3) idle(1'b1);
        checkOutput("stall_hold_3", fetch_pc, 32'h400);

        // aliasing at index 2
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h108, 3'd2, 32'h20, 1'b0, 32'h0, 32'h128);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h148, 3'd1, 32'h10, 1'b1, 32'h0, 32'h14C);
        checkOutput("alias_redirect", fetch_pc, 32'h158);
        jumpTo(32'h108);
        checkOutput("alias_old_miss", 32'(pred_taken), 32'h0);
        jumpTo(32'h148);
        checkOutput("alias_new_taken", 32'(pred_taken), 32'h1);
        checkOutput("alias_new_target", pred_npc, 32'h158);

        // randomized traffic over a small PC window so BTB entries get reused and aliased
        for (int i = 0; i < 600; i++) begin
            pc  = 32'h100 + (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 1)) << 6);
            op  = 3'($urandom_range(0, 7));
            off = (32'($urandom_range(0, 63)) << 2) - 32'd128;
            br  = 1'($urandom_range(0, 1));
            rpc = 32'h200 + (32'($urandom_range(0, 63)) << 2);
            case ($urandom_range(0, 2))
                0:       pn = modelPredict(pc);
                1:       pn = modelActual(op, pc, off, br, rpc);
                default: pn = pc + 32'd4;
            endcase
            applyStimulus(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 3) != 0), pc, op, off, br, rpc, pn);
        end
        idle(1'b0);

        checkOutput("scoreboard_drain", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
